// File: rtl/fir_pkg.sv
// Shared widths, limits and types for the FIR output path.
// Used by fir_decimator and fir_dec_fifo2.
package fir_pkg;

  localparam int FIR_OUT_W = 11;
  localparam int DEC_OUT_W = 8;

  localparam int DEC_SAT_MAX = (1 << (DEC_OUT_W - 1)) - 1;
  localparam int DEC_SAT_MIN = -(1 << (DEC_OUT_W - 1));

  typedef logic signed [DEC_OUT_W-1:0] sat_t;

endpackage

// File: rtl/fir_dec_fifo2.sv
// Two-entry ready/valid FIFO for decimated results.
// Ports: clk, reset (sync, high), i_push/i_data in,
//   o_valid/i_ready/o_data out, o_push_drop = push lost to a full buffer.
module fir_dec_fifo2
  import fir_pkg::*;
#(
  parameter int W = DEC_OUT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_push_drop
);

  logic [1:0]   r_cnt;
  logic [W-1:0] r_m0;
  logic [W-1:0] r_m1;
  logic         w_pop;

  assign o_valid     = (r_cnt != 2'd0);
  assign o_data      = r_m0;
  assign w_pop       = o_valid && i_ready;
  // a pop in the same cycle frees the slot, so only a stalled full FIFO drops
  assign o_push_drop = i_push && (r_cnt == 2'd2) && !w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 2'd0;
      r_m0  <= '0;
      r_m1  <= '0;
    end else begin
      unique case (1'b1)
        (i_push && w_pop): begin
          if (r_cnt == 2'd2) begin
            r_m0 <= r_m1;
            r_m1 <= i_data;
          end else begin
            r_m0 <= i_data;
          end
        end
        (i_push && !w_pop): begin
          if (r_cnt == 2'd0) begin
            r_m0  <= i_data;
            r_cnt <= 2'd1;
          end else if (r_cnt == 2'd1) begin
            r_m1  <= i_data;
            r_cnt <= 2'd2;
          end
        end
        (!i_push && w_pop): begin
          r_m0  <= r_m1;
          r_cnt <= r_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fir_decimator.sv
// Accumulate-and-dump decimator with saturation and a 2-entry output buffer.
// Ports: clk, reset (sync, high); s_tvalid/s_tdata input stream; i_clr
//   restarts the phase; m_tvalid/m_tready/m_tdata output; o_overflow sticky.
// Optional macro FIR_DEC_ROUND_EN: round half up instead of floor.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int DECIM_LOG2 = 2,
  parameter int IN_W       = FIR_OUT_W,
  parameter int OUT_W      = DEC_OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_tvalid,
  input  logic [IN_W-1:0]  s_tdata,
  input  logic             i_clr,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [OUT_W-1:0] m_tdata,
  output logic             o_overflow
);

  localparam int AW   = IN_W + DECIM_LOG2;
  localparam int PH_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;

  localparam logic [PH_W-1:0] PH_LAST =
    PH_W'((1 << DECIM_LOG2) - 1);
  localparam logic signed [AW:0] L_MAX =
    (AW+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [AW:0] L_MIN =
    (AW+1)'(-(1 << (OUT_W - 1)));

  logic [PH_W-1:0]   r_ph;
  logic [AW-1:0]     r_acc;
  logic              r_ovf;

  logic signed [AW:0] w_base;
  logic signed [AW:0] w_in;
  logic signed [AW:0] w_sum;
  logic signed [AW:0] w_rsum;
  logic signed [AW:0] w_shr;
  logic [OUT_W-1:0]   w_res;
  logic               w_dump;
  logic               w_push;
  logic               w_drop;

  // phase 0 starts a new block: ignore the old accumulator
  assign w_base = (r_ph == '0) ? '0 : {r_acc[AW-1], r_acc};
  assign w_in   = {{(DECIM_LOG2 + 1){s_tdata[IN_W-1]}}, s_tdata};
  assign w_sum  = w_base + w_in;

`ifdef FIR_DEC_ROUND_EN
  if (DECIM_LOG2 > 0) begin : g_rnd
    assign w_rsum = w_sum + (AW+1)'(1 << (DECIM_LOG2 - 1));
  end else begin : g_nornd
    assign w_rsum = w_sum;
  end
`else
  assign w_rsum = w_sum;
`endif

  assign w_shr  = w_rsum >>> DECIM_LOG2;
  assign w_dump = (r_ph == PH_LAST);
  assign w_push = s_tvalid && !i_clr && w_dump;

  always_comb begin
    w_res = w_shr[OUT_W-1:0];
    unique case (1'b1)
      (w_shr > L_MAX): w_res = L_MAX[OUT_W-1:0];
      (w_shr < L_MIN): w_res = L_MIN[OUT_W-1:0];
      default:         w_res = w_shr[OUT_W-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ph  <= '0;
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_drop) r_ovf <= 1'b1;
      if (i_clr) begin
        r_ph  <= '0;
        r_acc <= '0;
      end else if (s_tvalid) begin
        r_acc <= w_sum[AW-1:0];
        r_ph  <= w_dump ? '0 : r_ph + 1'b1;
      end
    end
  end

  assign o_overflow = r_ovf;

  fir_dec_fifo2 #(.W(OUT_W)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_data      (w_res),
    .o_valid     (m_tvalid),
    .i_ready     (m_tready),
    .o_data      (m_tdata),
    .o_push_drop (w_drop)
  );

endmodule

// File: tb/tb_fir_decimator.sv
// Self-checking bench for fir_decimator (default parameters).
// Vector table plus hand sequences; outputs checked through a queue.
module tb_fir_decimator;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_tvalid;
  logic [10:0] s_tdata;
  logic        i_clr;
  logic        m_tvalid;
  logic        m_tready;
  logic [7:0]  m_tdata;
  logic        o_overflow;

  int n_chk = 0;
  int n_err = 0;
  int n_out = 0;
  int q[$];

  typedef struct {
    int s[4];
    int e_tr;
    int e_rd;
  } vec_t;

  vec_t vt[12];

  always #5 clk = ~clk;

  fir_decimator dut (
    .clk        (clk),
    .reset      (reset),
    .s_tvalid   (s_tvalid),
    .s_tdata    (s_tdata),
    .i_clr      (i_clr),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .o_overflow (o_overflow)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // handshake completes on the coming edge; inputs are stable at negedge
  always @(negedge clk) begin
    if (!reset && m_tvalid && m_tready) begin
      n_out++;
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_out: got %0d expected none",
                 $signed(m_tdata));
      end else begin
        chk("out_data", int'($signed(m_tdata)), q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input bit dump, input int exp);
    s_tvalid = 1'b1;
    s_tdata  = 11'(x);
    if (dump) q.push_back(exp);
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 30 && q.size() != 0; i++) tick();
    if (q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_timeout: got %0d pending expected 0", nm, q.size());
      q.delete();
    end
    tick();
    tick();
  endtask

  task automatic blk(input int v, input int exp);
    for (int k = 0; k < 4; k++) send(v, k == 3, exp);
  endtask

  initial begin
    int exp;
    int n0;
    vt[0]  = '{'{100, 100, 100, 100}, 100, 100};
    vt[1]  = '{'{1023, 1023, 1023, 1023}, 127, 127};
    vt[2]  = '{'{-1024, -1024, -1024, -1024}, -128, -128};
    vt[3]  = '{'{1, 1, 1, 0}, 0, 1};
    vt[4]  = '{'{-1, -1, -1, -1}, -1, -1};
    vt[5]  = '{'{-3, 0, 0, 0}, -1, -1};
    vt[6]  = '{'{7, 0, 0, 0}, 1, 2};
    vt[7]  = '{'{-600, -600, -600, -600}, -128, -128};
    vt[8]  = '{'{10, 20, 30, 41}, 25, 25};
    vt[9]  = '{'{-5, -5, -5, -6}, -6, -5};
    vt[10] = '{'{128, 128, 128, 127}, 127, 127};
    vt[11] = '{'{-129, -129, -129, -128}, -129 < -128 ? -128 : 0, -128};

    reset = 1'b1; s_tvalid = 1'b0; s_tdata = '0;
    i_clr = 1'b0; m_tready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", int'(m_tvalid), 0);
    chk("rst_data", int'(m_tdata), 0);
    chk("rst_ovf", int'(o_overflow), 0);

    // single block: one-cycle valid pulse right after the dump sample
    send(100, 0, 0); send(100, 0, 0); send(100, 0, 0);
    send(100, 1, 100);
    @(negedge clk);
    chk("lat_valid_t1", int'(m_tvalid), 1);
    @(negedge clk);
    chk("lat_valid_t2", int'(m_tvalid), 0);
    tick();

    for (int i = 0; i < 12; i++) begin
`ifdef FIR_DEC_ROUND_EN
      exp = vt[i].e_rd;
`else
      exp = vt[i].e_tr;
`endif
      for (int k = 0; k < 4; k++) send(vt[i].s[k], k == 3, exp);
    end
    drain("table");

    // stall: two results buffered, third dropped
    m_tready = 1'b0;
    blk(5, 5); blk(5, 5);
    tick();
    chk("ovf_before", int'(o_overflow), 0);
    blk(5, 0);
    q.delete(); q.push_back(5); q.push_back(5);
    tick();
    chk("ovf_set", int'(o_overflow), 1);
    chk("ovf_valid", int'(m_tvalid), 1);
    chk("ovf_head", int'($signed(m_tdata)), 5);
    n0 = n_out;
    m_tready = 1'b1;
    drain("stall");
    chk("stall_count", n_out - n0, 2);
    chk("stall_empty", int'(m_tvalid), 0);
    chk("ovf_sticky", int'(o_overflow), 1);

    // i_clr discards a partial block
    n0 = n_out;
    send(50, 0, 0); send(50, 0, 0);
    i_clr = 1'b1; tick(); i_clr = 1'b0;
    blk(8, 8);
    drain("clr");
    chk("clr_count", n_out - n0, 1);

    // i_clr together with a valid sample drops that sample
    n0 = n_out;
    send(8, 0, 0); send(8, 0, 0); send(8, 0, 0);
    i_clr = 1'b1; s_tvalid = 1'b1; s_tdata = 11'd100;
    tick();
    i_clr = 1'b0; s_tvalid = 1'b0;
    blk(8, 8);
    drain("clrv");
    chk("clrv_count", n_out - n0, 1);

    // reset drops buffered data and the partial block
    m_tready = 1'b0;
    blk(7, 7);
    send(9, 0, 0); send(9, 0, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    q.delete();
    chk("rst2_valid", int'(m_tvalid), 0);
    chk("rst2_data", int'(m_tdata), 0);
    chk("rst2_ovf", int'(o_overflow), 0);
    m_tready = 1'b1;
    n0 = n_out;
    blk(20, 20);
    drain("rst2");
    chk("rst2_count", n_out - n0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_decimator.md
# fir_decimator

Decimating output stage placed directly downstream of the FIR core. Consumes the FIR's 11-bit signed result stream, sums each block of 2^DECIM_LOG2 samples and divides by the block size (accumulate-and-dump). Saturates the block average to an 8-bit signed value and presents it on a ready/valid output through a 2-entry buffer. Serves as a narrower, lower-rate interface for the chip pins or a downstream consumer.

## Interface
- DECIM_LOG2, 2: log2 of the decimation factor D; legal range 0..4.
- IN_W, 11: input sample width, two's complement.
- OUT_W, 8: output sample width, two's complement.
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous reset, active-high.
- s_tvalid  in  1  the input sample is valid; there is no input backpressure and every valid sample is consumed.
- s_tdata  in  IN_W  FIR output sample (o_y_n).
- i_clr  in  1  synchronous restart of the decimation phase.
- m_tvalid  out  1  the output buffer holds at least one result.
- m_tready  in  1  downstream accepts m_tdata.
- m_tdata  out  OUT_W  decimated result (head of the buffer).
- o_overflow  out  1  sticky flag; set when a result is dropped.

## Operation
- Reset values: m_tvalid=0, m_tdata=0, o_overflow=0. Reset also clears the phase counter, the accumulator, and both buffer entries.
- Phase counter ph runs 0..D-1 and advances on each s_tvalid. Accumulator width is IN_W+DECIM_LOG2, sign-extended, so it never overflows.
- ph=0 with s_tvalid: acc loads sign-extended s_tdata (no separate clear cycle).
- ph≠0 with s_tvalid: acc adds s_tdata.
- ph=D-1 with s_tvalid (the dump):
  - sum = acc + s_tdata.
  - res = sum >>> DECIM_LOG2 (arithmetic shift).
  - res saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - res is pushed into the buffer, and ph wraps to 0.
- D=1 (DECIM_LOG2=0): every sample dumps; the block reduces to saturation plus buffering.
- Buffer: 2-entry FIFO. A pop happens when m_tvalid && m_tready.
  - Push while the FIFO holds 2 entries with no pop: the new result is dropped, o_overflow is set, and the stored entries are unchanged.
  - Push and pop in the same cycle while full: the push succeeds and no overflow occurs.
  - Push into an empty FIFO: data appears at the head on the next cycle.
- i_clr: ph←0 and acc←0. Any sample presented in the same cycle is discarded. The buffer contents and o_overflow are kept.
- o_overflow clears only on reset.
- Reset has priority over i_clr, and i_clr has priority over s_tvalid.

## Timing
- Latency: dump sample accepted at cycle t → m_tvalid=1 with the result at t+1, if the buffer was empty.
- m_tdata stays stable while m_tvalid && !m_tready.
- Sustained throughput is 1 output per D input samples. The buffer absorbs up to 2 results of downstream stall.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- FIR_DEC_ROUND_EN defined: before the shift, sum gets 2^(DECIM_LOG2-1) added (round half up). This adder is absent when DECIM_LOG2=0.
- FIR_DEC_ROUND_EN undefined: truncation (floor) only.

## Structure
- Package fir_pkg holds:
  - FIR_OUT_W=11, the shared FIR output width.
  - DEC_OUT_W=8.
  - The saturation min/max constants.
  - A sat_t signed typedef for the output sample.
- One sub-module, fir_dec_fifo2: 2-entry ready/valid FIFO with a push_drop output that drives the overflow flag.
- Accumulator, phase counter, rounding and saturation stay in fir_decimator.

## Test plan
Defaults apply unless stated.
- Four samples of 100, m_tready=1 → one output of 100, with m_tvalid high for exactly 1 cycle, starting 1 cycle after the 4th sample.
- Four samples of 1023 → 127. Four samples of -1024 → -128 (0x80).
- Samples 1,1,1,0 → 0 without FIR_DEC_ROUND_EN; 1 with it. Samples -1,-1,-1,-1 → -1 in both builds.
- m_tready=0, 12 samples of 5 → buffer holds 5,5. The third result is dropped and o_overflow=1. Then raise m_tready → exactly two outputs of 5.
- Two samples of 50, then i_clr, then four samples of 8 → a single output of 8. Also check that i_clr asserted together with s_tvalid discards that sample.
- reset asserted after two samples with one result buffered → m_tvalid=0 next cycle. The next four samples of 20 → 20.
